// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath (master) and the hazard unit (slave).
// The datapath drives register numbers and stage flags; the hazard unit returns forwarding selects and stalls.
interface pipeline_hazard_ctrl_if;
    logic [4:0] RsD;
    logic [4:0] RtD;
    logic [4:0] RsE;
    logic [4:0] RtE;
    logic [4:0] WriteRegE;
    logic [4:0] WriteRegM;
    logic [4:0] WriteRegW;
    logic       RegWriteE;
    logic       RegWriteM;
    logic       RegWriteW;
    logic       MemtoRegE;
    logic       MemtoRegM;
    logic       BranchD;
    logic       DivStartE;
    logic       MulStartE;
    logic [1:0] ForwardAE;
    logic [1:0] ForwardBE;
    logic       ForwardAD;
    logic       ForwardBD;
    logic       StallF;
    logic       StallD;
    logic       StallE;
    logic       FlushE;
    logic       MdBusy;
    logic       MdDone;

    modport master (
        output RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
        output RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
        output BranchD, DivStartE, MulStartE,
        input  ForwardAE, ForwardBE, ForwardAD, ForwardBD,
        input  StallF, StallD, StallE, FlushE, MdBusy, MdDone
    );

    modport slave (
        input  RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW,
        input  RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM,
        input  BranchD, DivStartE, MulStartE,
        output ForwardAE, ForwardBE, ForwardAD, ForwardBD,
        output StallF, StallD, StallE, FlushE, MdBusy, MdDone
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline hazard unit: EX/decode forwarding, load-use and branch stalls,
// plus a multi-cycle multiply/divide occupancy tracker that holds the front of the pipe.
module pipeline_hazard_ctrl #(
    parameter int DIV_CYCLES = 32,
    parameter int MUL_CYCLES = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    pipeline_hazard_ctrl_if.slave  hz
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_e;

    localparam logic [5:0] DIV_LOAD = 6'(DIV_CYCLES - 1);
    localparam logic [5:0] MUL_LOAD = 6'(MUL_CYCLES - 1);

    md_state_e  state_q;
    logic [5:0] cnt_q;
    logic       md_busy_q;
    logic       md_done_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            md_busy_q <= 1'b0;
            md_done_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hz.DivStartE) begin
                        cnt_q     <= DIV_LOAD;
                        state_q   <= BUSY;
                        md_busy_q <= 1'b1;
                    end else if (hz.MulStartE) begin
                        cnt_q     <= MUL_LOAD;
                        state_q   <= BUSY;
                        md_busy_q <= 1'b1;
                    end
                end
                BUSY: begin
                    if (cnt_q != 6'd0) begin
                        cnt_q <= cnt_q - 6'd1;
                    end else begin
                        state_q   <= DONE;
                        md_busy_q <= 1'b0;
                        md_done_q <= 1'b1;
                    end
                end
                DONE: begin
                    // The finished instruction is still in EX this cycle; its start flag must not relaunch.
                    state_q   <= IDLE;
                    md_done_q <= 1'b0;
                end
                default: begin
                    state_q   <= IDLE;
                    md_busy_q <= 1'b0;
                    md_done_q <= 1'b0;
                end
            endcase
        end
    end

    logic [4:0] src_e [2];
    logic [4:0] src_d [2];
    logic [1:0] fwd_e [2];
    logic       fwd_d [2];
    logic       e_hit [2];
    logic       mload_hit [2];

    assign src_e[0] = hz.RsE;
    assign src_e[1] = hz.RtE;
    assign src_d[0] = hz.RsD;
    assign src_d[1] = hz.RtD;

    logic m_valid;
    logic w_valid;
    logic e_valid;
    assign m_valid = hz.RegWriteM & (hz.WriteRegM != 5'd0);
    assign w_valid = hz.RegWriteW & (hz.WriteRegW != 5'd0);
    assign e_valid = hz.RegWriteE & (hz.WriteRegE != 5'd0);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_operand
            logic m_hit;
            logic w_hit;
            assign m_hit        = m_valid & (hz.WriteRegM == src_e[gi]);
            assign w_hit        = w_valid & (hz.WriteRegW == src_e[gi]);
            assign fwd_e[gi]    = m_hit ? 2'b10 : (w_hit ? 2'b01 : 2'b00);
            assign fwd_d[gi]    = m_valid & (hz.WriteRegM == src_d[gi]);
            assign e_hit[gi]    = e_valid & (hz.WriteRegE == src_d[gi]);
            assign mload_hit[gi] = hz.MemtoRegM & (hz.WriteRegM != 5'd0) & (hz.WriteRegM == src_d[gi]);
        end
    endgenerate

    logic lwstall;
    logic brstall;
    logic mdstall;
    logic front_stall;

    assign lwstall     = hz.MemtoRegE & (e_hit[0] | e_hit[1]);
    assign brstall     = hz.BranchD & (e_hit[0] | e_hit[1] | mload_hit[0] | mload_hit[1]);
    assign mdstall     = ((state_q == IDLE) & (hz.DivStartE | hz.MulStartE)) | (state_q == BUSY);
    assign front_stall = lwstall | brstall | mdstall;

    // Every output is forced quiet while reset is held, even before the state register clears.
    assign hz.ForwardAE = reset ? 2'b00 : fwd_e[0];
    assign hz.ForwardBE = reset ? 2'b00 : fwd_e[1];
    assign hz.ForwardAD = ~reset & fwd_d[0];
    assign hz.ForwardBD = ~reset & fwd_d[1];
    assign hz.StallF    = ~reset & front_stall;
    assign hz.StallD    = ~reset & front_stall;
    assign hz.StallE    = ~reset & mdstall;
    assign hz.FlushE    = ~reset & (lwstall | brstall) & ~mdstall;
    assign hz.MdBusy    = ~reset & md_busy_q;
    assign hz.MdDone    = ~reset & md_done_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: each step pushes its expected output vector,
// then pops and compares it once the outputs have settled mid-cycle.
module tb_pipeline_hazard_ctrl;
    logic clock;
    logic reset;

    pipeline_hazard_ctrl_if hz();

    pipeline_hazard_ctrl #(
        .DIV_CYCLES(32),
        .MUL_CYCLES(4)
    ) dut (
        .clock (clock),
        .reset (reset),
        .hz    (hz)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic [11:0] v;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    // Vector order: ForwardAE ForwardBE ForwardAD ForwardBD StallF StallD StallE FlushE MdBusy MdDone
    function automatic logic [11:0] mk(input logic [1:0] ae, input logic [1:0] be,
                                       input logic ad, input logic bd, input logic sf, input logic sd,
                                       input logic se, input logic fe, input logic bz, input logic dn);
        return {ae, be, ad, bd, sf, sd, se, fe, bz, dn};
    endfunction

    function automatic logic [11:0] obs_vec();
        return {hz.ForwardAE, hz.ForwardBE, hz.ForwardAD, hz.ForwardBD, hz.StallF, hz.StallD,
                hz.StallE, hz.FlushE, hz.MdBusy, hz.MdDone};
    endfunction

    function automatic logic [11:0] model_comb();
        logic [1:0] ae;
        logic [1:0] be;
        logic       ad;
        logic       bd;
        logic       lw;
        logic       br;
        logic       mv;
        logic       wv;
        logic       ev;
        logic       lv;
        mv = hz.RegWriteM && hz.WriteRegM != 5'd0;
        wv = hz.RegWriteW && hz.WriteRegW != 5'd0;
        ev = hz.RegWriteE && hz.WriteRegE != 5'd0;
        lv = hz.MemtoRegM && hz.WriteRegM != 5'd0;
        ae = (mv && hz.WriteRegM == hz.RsE) ? 2'b10 : ((wv && hz.WriteRegW == hz.RsE) ? 2'b01 : 2'b00);
        be = (mv && hz.WriteRegM == hz.RtE) ? 2'b10 : ((wv && hz.WriteRegW == hz.RtE) ? 2'b01 : 2'b00);
        ad = mv && hz.WriteRegM == hz.RsD;
        bd = mv && hz.WriteRegM == hz.RtD;
        lw = hz.MemtoRegE && ev && (hz.WriteRegE == hz.RsD || hz.WriteRegE == hz.RtD);
        br = hz.BranchD && ((ev && (hz.WriteRegE == hz.RsD || hz.WriteRegE == hz.RtD)) ||
                            (lv && (hz.WriteRegM == hz.RsD || hz.WriteRegM == hz.RtD)));
        return mk(ae, be, ad, bd, lw | br, lw | br, 1'b0, lw | br, 1'b0, 1'b0);
    endfunction

    task automatic clr();
        hz.RsD = '0; hz.RtD = '0; hz.RsE = '0; hz.RtE = '0;
        hz.WriteRegE = '0; hz.WriteRegM = '0; hz.WriteRegW = '0;
        hz.RegWriteE = 1'b0; hz.RegWriteM = 1'b0; hz.RegWriteW = 1'b0;
        hz.MemtoRegE = 1'b0; hz.MemtoRegM = 1'b0; hz.BranchD = 1'b0;
        hz.DivStartE = 1'b0; hz.MulStartE = 1'b0;
    endtask

    task automatic test_reset();
        exp_t        e;
        logic [11:0] got;
        for (int s = 0; s < 3; s++) begin
            @(negedge clock);
            clr();
            if (s < 2) begin
                reset = 1'b1;
                hz.RsE = 5'd5; hz.RtE = 5'd5; hz.RegWriteM = 1'b1; hz.WriteRegM = 5'd5;
                hz.RsD = 5'd5; hz.RtD = 5'd7; hz.MemtoRegE = 1'b1; hz.RegWriteE = 1'b1;
                hz.WriteRegE = 5'd7; hz.BranchD = 1'b1; hz.MulStartE = 1'b1;
            end else begin
                reset = 1'b0;
            end
            exp_q.push_back('{$sformatf("reset%0d", s), 12'h000});
            #2;
            e = exp_q.pop_front();
            got = obs_vec();
            checks++;
            if (got !== e.v) begin
                errors++;
                $display("FAIL %s got=%b want=%b", e.name, got, e.v);
            end else $display("ok   %s out=%b", e.name, got);
        end
    endtask

    task automatic test_forward();
        exp_t        e;
        logic [11:0] got;
        logic [11:0] ev;
        for (int s = 0; s < 6; s++) begin
            @(negedge clock);
            clr();
            ev = '0;
            case (s)
                0: begin
                    hz.RsE = 5'd5; hz.RegWriteM = 1'b1; hz.WriteRegM = 5'd5;
                    hz.RegWriteW = 1'b1; hz.WriteRegW = 5'd5;
                    ev = mk(2'b10, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
                end
                1: begin
                    hz.RsE = 5'd5; hz.WriteRegM = 5'd5; hz.RegWriteW = 1'b1; hz.WriteRegW = 5'd5;
                    ev = mk(2'b01, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
                end
                2: begin
                    hz.RsE = 5'd5; hz.RegWriteM = 1'b1; hz.RegWriteW = 1'b1;
                    ev = mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0);
                end
                3: begin
                    hz.RsE = 5'd9; hz.RtE = 5'd9; hz.RegWriteM = 1'b1; hz.WriteRegM = 5'd9;
                    hz.RegWriteW = 1'b1; hz.WriteRegW = 5'd9;
                    ev = mk(2'b10, 2'b10, 0, 0, 0, 0, 0, 0, 0, 0);
                end
                4: begin
                    hz.RsE = 5'd4; hz.RtE = 5'd3; hz.RegWriteM = 1'b1; hz.WriteRegM = 5'd4;
                    hz.RegWriteW = 1'b1; hz.WriteRegW = 5'd3;
                    ev = mk(2'b10, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0);
                end
                default: begin
                    hz.RsD = 5'd6; hz.RtD = 5'd6; hz.RegWriteM = 1'b1; hz.WriteRegM = 5'd6;
                    ev = mk(2'b00, 2'b00, 1, 1, 0, 0, 0, 0, 0, 0);
                end
            endcase
            exp_q.push_back('{$sformatf("fwd%0d", s), ev});
            #2;
            e = exp_q.pop_front();
            got = obs_vec();
            checks++;
            if (got !== e.v) begin
                errors++;
                $display("FAIL %s got=%b want=%b", e.name, got, e.v);
            end else $display("ok   %s out=%b", e.name, got);
        end
    endtask

    task automatic test_stalls();
        exp_t        e;
        logic [11:0] got;
        logic [11:0] ev;
        for (int s = 0; s < 8; s++) begin
            @(negedge clock);
            clr();
            ev = '0;
            case (s)
                0: begin
                    hz.MemtoRegE = 1'b1; hz.RegWriteE = 1'b1; hz.WriteRegE = 5'd7; hz.RtD = 5'd7;
                    ev = mk(2'b00, 2'b00, 0, 0, 1, 1, 0, 1, 0, 0);
                end
                1: begin
                    hz.MemtoRegE = 1'b1; hz.RegWriteE = 1'b1; hz.RtD = 5'd0;
                end
                2: begin
                    hz.MemtoRegE = 1'b1; hz.RegWriteE = 1'b1; hz.WriteRegE = 5'd7; hz.RsD = 5'd7;
                    ev = mk(2'b00, 2'b00, 0, 0, 1, 1, 0, 1, 0, 0);
                end
                3: begin
                    hz.MemtoRegE = 1'b1; hz.WriteRegE = 5'd7; hz.RsD = 5'd7;
                end
                4: begin
                    hz.BranchD = 1'b1; hz.RegWriteE = 1'b1; hz.WriteRegE = 5'd8; hz.RsD = 5'd8;
                    ev = mk(2'b00, 2'b00, 0, 0, 1, 1, 0, 1, 0, 0);
                end
                5: begin
                    hz.BranchD = 1'b1; hz.MemtoRegM = 1'b1; hz.WriteRegM = 5'd8; hz.RtD = 5'd8;
                    ev = mk(2'b00, 2'b00, 0, 0, 1, 1, 0, 1, 0, 0);
                end
                6: begin
                    hz.RegWriteE = 1'b1; hz.WriteRegE = 5'd8; hz.RsD = 5'd8;
                end
                default: begin
                    hz.BranchD = 1'b1; hz.RegWriteM = 1'b1; hz.WriteRegM = 5'd8; hz.RsD = 5'd8;
                    ev = mk(2'b00, 2'b00, 1, 0, 0, 0, 0, 0, 0, 0);
                end
            endcase
            exp_q.push_back('{$sformatf("stall%0d", s), ev});
            #2;
            e = exp_q.pop_front();
            got = obs_vec();
            checks++;
            if (got !== e.v) begin
                errors++;
                $display("FAIL %s got=%b want=%b", e.name, got, e.v);
            end else $display("ok   %s out=%b", e.name, got);
        end
    endtask

    task automatic test_random();
        exp_t        e;
        logic [11:0] got;
        for (int s = 0; s < 40; s++) begin
            @(negedge clock);
            clr();
            hz.RsD = 5'($urandom_range(0, 3)); hz.RtD = 5'($urandom_range(0, 3));
            hz.RsE = 5'($urandom_range(0, 3)); hz.RtE = 5'($urandom_range(0, 3));
            hz.WriteRegE = 5'($urandom_range(0, 3)); hz.WriteRegM = 5'($urandom_range(0, 3));
            hz.WriteRegW = 5'($urandom_range(0, 3));
            hz.RegWriteE = 1'($urandom_range(0, 1)); hz.RegWriteM = 1'($urandom_range(0, 1));
            hz.RegWriteW = 1'($urandom_range(0, 1)); hz.MemtoRegE = 1'($urandom_range(0, 1));
            hz.MemtoRegM = 1'($urandom_range(0, 1)); hz.BranchD = 1'($urandom_range(0, 1));
            exp_q.push_back('{$sformatf("rand%0d", s), model_comb()});
            #2;
            e = exp_q.pop_front();
            got = obs_vec();
            checks++;
            if (got !== e.v) begin
                errors++;
                $display("FAIL %s got=%b want=%b", e.name, got, e.v);
            end else $display("ok   %s out=%b", e.name, got);
        end
    endtask

    task automatic test_mul();
        exp_t        e;
        logic [11:0] got;
        logic [11:0] ev;
        for (int s = 0; s < 8; s++) begin
            @(negedge clock);
            clr();
            hz.MulStartE = (s <= 5);
            if (s == 0)                ev = mk(2'b00, 2'b00, 0, 0, 1, 1, 1, 0, 0, 0);
            else if (s >= 1 && s <= 4) ev = mk(2'b00, 2'b00, 0, 0, 1, 1, 1, 0, 1, 0);
            else if (s == 5)           ev = mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1);
            else                       ev = '0;
            exp_q.push_back('{$sformatf("mul_t%0d", s), ev});
            #2;
            e = exp_q.pop_front();
            got = obs_vec();
            checks++;
            if (got !== e.v) begin
                errors++;
                $display("FAIL %s got=%b want=%b", e.name, got, e.v);
            end else $display("ok   %s out=%b", e.name, got);
        end
    endtask

    task automatic test_div_priority();
        exp_t        e;
        logic [11:0] got;
        logic [11:0] ev;
        for (int s = 0; s < 36; s++) begin
            @(negedge clock);
            clr();
            hz.DivStartE = (s <= 33);
            hz.MulStartE = (s <= 33);
            if (s == 0)                 ev = mk(2'b00, 2'b00, 0, 0, 1, 1, 1, 0, 0, 0);
            else if (s >= 1 && s <= 32) ev = mk(2'b00, 2'b00, 0, 0, 1, 1, 1, 0, 1, 0);
            else if (s == 33)           ev = mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1);
            else                        ev = '0;
            exp_q.push_back('{$sformatf("div_t%0d", s), ev});
            #2;
            e = exp_q.pop_front();
            got = obs_vec();
            checks++;
            if (got !== e.v) begin
                errors++;
                $display("FAIL %s got=%b want=%b", e.name, got, e.v);
            end else $display("ok   %s out=%b", e.name, got);
        end
    endtask

    task automatic test_lw_during_busy();
        exp_t        e;
        logic [11:0] got;
        logic [11:0] ev;
        for (int s = 0; s < 7; s++) begin
            @(negedge clock);
            clr();
            hz.MulStartE = (s <= 5);
            if (s == 0 || s == 2 || s == 3) begin
                hz.MemtoRegE = 1'b1; hz.RegWriteE = 1'b1; hz.WriteRegE = 5'd12; hz.RsD = 5'd12;
            end
            if (s == 0)                ev = mk(2'b00, 2'b00, 0, 0, 1, 1, 1, 0, 0, 0);
            else if (s >= 1 && s <= 4) ev = mk(2'b00, 2'b00, 0, 0, 1, 1, 1, 0, 1, 0);
            else if (s == 5)           ev = mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1);
            else                       ev = '0;
            exp_q.push_back('{$sformatf("lwbusy_t%0d", s), ev});
            #2;
            e = exp_q.pop_front();
            got = obs_vec();
            checks++;
            if (got !== e.v) begin
                errors++;
                $display("FAIL %s got=%b want=%b", e.name, got, e.v);
            end else $display("ok   %s out=%b", e.name, got);
        end
    endtask

    task automatic test_reset_busy();
        exp_t        e;
        logic [11:0] got;
        logic [11:0] ev;
        // Divide loads 31 on entry to BUSY, so the counter reads 10 in step 22.
        for (int s = 0; s < 28; s++) begin
            @(negedge clock);
            clr();
            hz.DivStartE = (s <= 22);
            reset = (s == 22);
            if (s == 0)                 ev = mk(2'b00, 2'b00, 0, 0, 1, 1, 1, 0, 0, 0);
            else if (s >= 1 && s <= 21) ev = mk(2'b00, 2'b00, 0, 0, 1, 1, 1, 0, 1, 0);
            else                        ev = '0;
            exp_q.push_back('{$sformatf("rstbusy_t%0d", s), ev});
            #2;
            e = exp_q.pop_front();
            got = obs_vec();
            checks++;
            if (got !== e.v) begin
                errors++;
                $display("FAIL %s got=%b want=%b", e.name, got, e.v);
            end else $display("ok   %s out=%b", e.name, got);
        end
    endtask

    initial begin
        reset = 1'b1;
        clr();
        test_reset();
        test_forward();
        test_stalls();
        test_random();
        test_mul();
        test_div_priority();
        test_lw_during_busy();
        test_reset_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout reached before summary");
        $fatal(1);
    end
endmodule
